// File: rtl/register_file_mp_if.sv
// Bus interface for register_file_mp: write ports, read ports with
// pipelined data/valid, reservation input and busy status.
// The master modport drives requests; the slave modport is the register file.
interface register_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int ADDR_WIDTH = 5
);
  logic                           en_n;
  logic [WR_PORTS-1:0]            wr;
  logic [ADDR_WIDTH*WR_PORTS-1:0] rw;
  logic [DATA_WIDTH*WR_PORTS-1:0] d;
  logic [RD_PORTS-1:0]            rd_req;
  logic [ADDR_WIDTH*RD_PORTS-1:0] rr;
  logic [DATA_WIDTH*RD_PORTS-1:0] q;
  logic [RD_PORTS-1:0]            q_valid;
  logic                           rsv;
  logic [ADDR_WIDTH-1:0]          rsv_addr;
  logic [RD_PORTS-1:0]            busy;

  modport master (
    output en_n, wr, rw, d, rd_req, rr, rsv, rsv_addr,
    input  q, q_valid, busy
  );

  modport slave (
    input  en_n, wr, rw, d, rd_req, rr, rsv, rsv_addr,
    output q, q_valid, busy
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file with busy scoreboard and a stallable read pipeline.
// Writes: highest-index port wins on an address collision; writes are never
// stalled by en_n. Reads: captured into the first pipeline stage when en_n=0,
// followed by DELAY more stages that also advance only when en_n=0.
// Optional feature macro RF_BYPASS_EN: same-cycle write-to-read forwarding of
// data, and busy reads 0 for an address being written this cycle unless it
// is also being reserved this cycle.
// Without RF_BYPASS_EN a same-cycle read returns the old value.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_PORTS   = 2,
  parameter int WR_PORTS   = 2,
  parameter int REG_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_DEPTH),
  parameter int DELAY      = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  register_file_mp_if.slave  bus
);

  localparam int PW = DATA_WIDTH * RD_PORTS;

  logic [DATA_WIDTH-1:0] mem_q [REG_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [REG_DEPTH];
  logic [REG_DEPTH-1:0]  sb_q;
  logic [REG_DEPTH-1:0]  sb_d;

  logic [PW-1:0]         pipe_data_q [DELAY+1];
  logic [PW-1:0]         pipe_data_d [DELAY+1];
  logic [RD_PORTS-1:0]   pipe_vld_q  [DELAY+1];
  logic [RD_PORTS-1:0]   pipe_vld_d  [DELAY+1];

  logic [PW-1:0]         rd_data;
  logic [RD_PORTS-1:0]   busy_c;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return int'(a) < REG_DEPTH;
  endfunction

  // Register 0 is hard-wired when ZERO_REG is set, so it is neither written
  // nor reserved.
  function automatic logic writable(input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Next register and scoreboard contents: writes in ascending port order so
  // the highest-index port lands last; reservation applied after writes so a
  // new producer keeps the bit set.
  always_comb begin
    mem_d = mem_q;
    sb_d  = sb_q;
    for (int k = 0; k < WR_PORTS; k++) begin
      if (bus.wr[k] && writable(bus.rw[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
        mem_d[bus.rw[k*ADDR_WIDTH +: ADDR_WIDTH]] = bus.d[k*DATA_WIDTH +: DATA_WIDTH];
        sb_d[bus.rw[k*ADDR_WIDTH +: ADDR_WIDTH]]  = 1'b0;
      end
    end
    if (bus.rsv && writable(bus.rsv_addr)) begin
      sb_d[bus.rsv_addr] = 1'b1;
    end
  end

  // Read data and busy status per lane, with optional same-cycle forwarding.
  always_comb begin
    rd_data = '0;
    busy_c  = '0;
    for (int i = 0; i < RD_PORTS; i++) begin
      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] v;
      logic                  b;
      a = bus.rr[i*ADDR_WIDTH +: ADDR_WIDTH];
      v = '0;
      b = 1'b0;
      if (writable(a)) begin
        v = mem_q[a];
        b = sb_q[a];
      end
`ifdef RF_BYPASS_EN
      for (int k = 0; k < WR_PORTS; k++) begin
        if (bus.wr[k] && writable(bus.rw[k*ADDR_WIDTH +: ADDR_WIDTH]) &&
            (bus.rw[k*ADDR_WIDTH +: ADDR_WIDTH] == a)) begin
          v = bus.d[k*DATA_WIDTH +: DATA_WIDTH];
          if (!(bus.rsv && (bus.rsv_addr == a))) b = 1'b0;
        end
      end
`endif
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = v;
      busy_c[i] = b;
    end
  end

  // Read pipeline advances as a whole only when en_n is low.
  always_comb begin
    pipe_data_d = pipe_data_q;
    pipe_vld_d  = pipe_vld_q;
    if (!bus.en_n) begin
      pipe_data_d[0] = rd_data;
      pipe_vld_d[0]  = bus.rd_req;
      for (int j = 1; j <= DELAY; j++) begin
        pipe_data_d[j] = pipe_data_q[j-1];
        pipe_vld_d[j]  = pipe_vld_q[j-1];
      end
    end
  end

  // State update; synchronous reset clears storage, scoreboard and pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < REG_DEPTH; r++) mem_q[r] <= '0;
      sb_q <= '0;
      for (int j = 0; j <= DELAY; j++) begin
        pipe_data_q[j] <= '0;
        pipe_vld_q[j]  <= '0;
      end
    end else begin
      mem_q       <= mem_d;
      sb_q        <= sb_d;
      pipe_data_q <= pipe_data_d;
      pipe_vld_q  <= pipe_vld_d;
    end
  end

  assign bus.q       = pipe_data_q[DELAY];
  assign bus.q_valid = pipe_vld_q[DELAY];
  assign bus.busy    = busy_c;

endmodule
